router_port_rx: RTL and testbench

//  Receiving end of one router output port: deserializes dout/valido_n/frameo_n into bytes (LSB-first).

---
 rtl/router_pkg.sv | 11 +
 rtl/router_port_rx_if.sv | 11 +
 rtl/router_rx_fifo.sv | 37 +++
 rtl/router_port_rx.sv | 73 +++++++
 tb/tb_router_port_rx.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router port receiver
package router_pkg;
  localparam int BYTE_W = 8;
  localparam int NUM_PORTS = 8;
  typedef enum logic [1:0] {SYNC, IDLE, RECV} rx_state_e;
  typedef struct packed {
    logic sop;
    logic eop;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/router_port_rx_if.sv
// router_port_rx_if: valid/ready byte stream with sop/eop tags
interface router_port_rx_if;
  import router_pkg::*;
  logic [BYTE_W-1:0] byte_data;
  logic byte_sop;
  logic byte_eop;
  logic byte_valid;
  logic byte_ready;
  modport master(output byte_data, byte_sop, byte_eop, byte_valid, input byte_ready);
  modport slave(input byte_data, byte_sop, byte_eop, byte_valid, output byte_ready);
endinterface

// File: rtl/router_rx_fifo.sv
// router_rx_fifo: sync FIFO of tagged bytes, push accepted when full if a pop frees a slot
module router_rx_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  rx_entry_t din,
  output rx_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  rx_entry_t mem [DEPTH];
  logic do_pop, do_push;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/router_port_rx.sv
// router_port_rx: deserialize router output port into a tagged byte stream with packet count and error flags
module router_port_rx
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 frameo_n,
  input  logic                 valido_n,
  input  logic                 dout,
  input  logic                 err_clear,
  router_port_rx_if.master     bs,
  output logic [CNT_W-1:0]     pkt_count,
  output logic                 err_partial,
  output logic                 err_overflow
);
  rx_state_e state;
  logic [2:0] bit_cnt, cnt_nxt;
  logic [BYTE_W-1:0] shreg, byte_w;
  logic first, got_byte;
  logic active, shift, push, pop, end_pkt, good, part, ovf, full, empty;
  rx_entry_t head;
  always_comb begin
    active = (state == RECV) || (state == IDLE && !frameo_n);
    shift = active && !valido_n;
    cnt_nxt = bit_cnt + 3'(shift);
    byte_w = shreg;
    byte_w[bit_cnt] = dout;
    push = shift && bit_cnt == 3'd7;
    pop = !empty && bs.byte_ready;
    end_pkt = state == RECV && frameo_n;
    good = end_pkt && cnt_nxt == 3'd0 && (got_byte || push);
    part = end_pkt && cnt_nxt != 3'd0;
    ovf = push && full && !pop;
  end
  router_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .din({first, frameo_n, byte_w}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign bs.byte_valid = !empty;
  assign bs.byte_data = empty ? '0 : head.data;
  assign bs.byte_sop = !empty && head.sop;
  assign bs.byte_eop = !empty && head.eop;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= SYNC;
      bit_cnt <= '0;
      shreg <= '0;
      first <= 1'b1;
      got_byte <= 1'b0;
      pkt_count <= '0;
      err_partial <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state <= state == SYNC ? (frameo_n ? IDLE : SYNC) : (frameo_n ? IDLE : RECV);
      if (shift) shreg <= byte_w;
      bit_cnt <= end_pkt ? 3'd0 : cnt_nxt;
      first <= end_pkt ? 1'b1 : (push ? 1'b0 : first);
      got_byte <= end_pkt ? 1'b0 : (got_byte || push);
      pkt_count <= pkt_count + CNT_W'(good);
      err_partial <= part || (err_partial && !err_clear);
      err_overflow <= ovf || (err_overflow && !err_clear);
    end
  end
endmodule

// File: tb/tb_router_port_rx.sv
// tb_router_port_rx: directed self-checking bench for router_port_rx
module tb_router_port_rx;
  import router_pkg::*;
  localparam int CW = 8;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic frameo_n = 1'b1;
  logic valido_n = 1'b1;
  logic dout = 1'b0;
  logic err_clear = 1'b0;
  logic [CW-1:0] pkt_count;
  logic err_partial, err_overflow;
  int n_chk = 0;
  int n_fail = 0;
  int gapc = 0;
  rx_entry_t got[$];
  router_port_rx_if bs();
  router_port_rx #(.FIFO_DEPTH(16), .CNT_W(CW)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .frameo_n(frameo_n),
    .valido_n(valido_n),
    .dout(dout),
    .err_clear(err_clear),
    .bs(bs),
    .pkt_count(pkt_count),
    .err_partial(err_partial),
    .err_overflow(err_overflow)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (bs.byte_valid && bs.byte_ready) got.push_back(rx_entry_t'({bs.byte_sop, bs.byte_eop, bs.byte_data}));
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic bit_(input logic b, input logic last, input logic gap);
    if (gap) begin
      valido_n = 1'b1;
      frameo_n = 1'b0;
      tick();
    end
    frameo_n = last;
    valido_n = 1'b0;
    dout = b;
    tick();
    valido_n = 1'b1;
  endtask
  task automatic send_bits(input logic [7:0] b, input int n, input logic last, input logic gaps);
    for (int i = 0; i < n; i++) begin
      gapc++;
      bit_(b[i], last && i == n - 1, gaps && gapc % 3 == 0);
    end
  endtask
  task automatic idle(input int n);
    frameo_n = 1'b1;
    valido_n = 1'b1;
    repeat (n) tick();
  endtask
  task automatic test_reset();
    bs.byte_ready = 1'b0;
    repeat (2) tick();
    n_chk++; if (bs.byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bs.byte_valid); end
    n_chk++; if (bs.byte_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", bs.byte_data); end
    n_chk++; if ({bs.byte_sop, bs.byte_eop} !== 2'b00) begin n_fail++; $display("FAIL reset_tags got=%b%b exp=00", bs.byte_sop, bs.byte_eop); end
    n_chk++; if (pkt_count !== 8'h00) begin n_fail++; $display("FAIL reset_cnt got=%h exp=00", pkt_count); end
    n_chk++; if ({err_partial, err_overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", err_partial, err_overflow); end
    reset_n = 1'b1;
    idle(2);
  endtask
  task automatic test_single();
    got.delete();
    bs.byte_ready = 1'b1;
    send_bits(8'hA5, 7, 1'b0, 1'b0);
    n_chk++; if (bs.byte_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b exp=0", bs.byte_valid); end
    bit_(1'b1, 1'b1, 1'b0);
    n_chk++; if (bs.byte_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", bs.byte_valid); end
    n_chk++; if (bs.byte_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", bs.byte_data); end
    n_chk++; if ({bs.byte_sop, bs.byte_eop} !== 2'b11) begin n_fail++; $display("FAIL single_tags got=%b%b exp=11", bs.byte_sop, bs.byte_eop); end
    n_chk++; if (pkt_count !== 8'd1) begin n_fail++; $display("FAIL single_cnt got=%h exp=01", pkt_count); end
    idle(2);
    n_chk++; if (got.size() !== 1) begin n_fail++; $display("FAIL single_popped got=%0d exp=1", got.size()); end
  endtask
  task automatic test_gaps();
    got.delete();
    gapc = 0;
    send_bits(8'h01, 8, 1'b0, 1'b1);
    send_bits(8'h02, 8, 1'b0, 1'b1);
    send_bits(8'h03, 8, 1'b1, 1'b1);
    idle(3);
    n_chk++; if (got.size() !== 3) begin n_fail++; $display("FAIL gaps_count got=%0d exp=3", got.size()); end
    else begin
      n_chk++; if (got[0] !== rx_entry_t'({2'b10, 8'h01})) begin n_fail++; $display("FAIL gaps_b0 got=%h exp=%h", got[0], {2'b10, 8'h01}); end
      n_chk++; if (got[1] !== rx_entry_t'({2'b00, 8'h02})) begin n_fail++; $display("FAIL gaps_b1 got=%h exp=%h", got[1], {2'b00, 8'h02}); end
      n_chk++; if (got[2] !== rx_entry_t'({2'b01, 8'h03})) begin n_fail++; $display("FAIL gaps_b2 got=%h exp=%h", got[2], {2'b01, 8'h03}); end
    end
    n_chk++; if (pkt_count !== 8'd2) begin n_fail++; $display("FAIL gaps_cnt got=%h exp=02", pkt_count); end
  endtask
  task automatic test_partial();
    got.delete();
    send_bits(8'h01, 8, 1'b0, 1'b0);
    send_bits(8'h02, 3, 1'b1, 1'b0);
    idle(3);
    n_chk++; if (got.size() !== 1) begin n_fail++; $display("FAIL partial_count got=%0d exp=1", got.size()); end
    else begin
      n_chk++; if (got[0] !== rx_entry_t'({2'b10, 8'h01})) begin n_fail++; $display("FAIL partial_b0 got=%h exp=%h", got[0], {2'b10, 8'h01}); end
    end
    n_chk++; if (err_partial !== 1'b1) begin n_fail++; $display("FAIL partial_flag got=%b exp=1", err_partial); end
    n_chk++; if (pkt_count !== 8'd2) begin n_fail++; $display("FAIL partial_cnt got=%h exp=02", pkt_count); end
  endtask
  task automatic test_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_chk++; if (err_partial !== 1'b0) begin n_fail++; $display("FAIL clear_partial got=%b exp=0", err_partial); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_chk++; if ({err_partial, err_overflow} !== 2'b00) begin n_fail++; $display("FAIL clear_idle got=%b%b exp=00", err_partial, err_overflow); end
    send_bits(8'h01, 8, 1'b0, 1'b0);
    send_bits(8'h02, 1, 1'b0, 1'b0);
    err_clear = 1'b1;
    bit_(1'b1, 1'b1, 1'b0);
    err_clear = 1'b0;
    n_chk++; if (err_partial !== 1'b1) begin n_fail++; $display("FAIL clear_set_wins got=%b exp=1", err_partial); end
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    idle(2);
    n_chk++; if (pkt_count !== 8'd2) begin n_fail++; $display("FAIL clear_cnt got=%h exp=02", pkt_count); end
  endtask
  task automatic test_overflow();
    got.delete();
    bs.byte_ready = 1'b0;
    for (int k = 0; k < 20; k++) send_bits(8'(8'h10 + k), 8, k == 19, 1'b0);
    n_chk++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", err_overflow); end
    n_chk++; if (pkt_count !== 8'd3) begin n_fail++; $display("FAIL ovf_cnt got=%h exp=03", pkt_count); end
    bs.byte_ready = 1'b1;
    idle(20);
    n_chk++; if (got.size() !== 16) begin n_fail++; $display("FAIL ovf_kept got=%0d exp=16", got.size()); end
    else begin
      for (int k = 0; k < 16; k++) begin
        n_chk++; if (got[k] !== rx_entry_t'({k == 0, 1'b0, 8'(8'h10 + k)})) begin n_fail++; $display("FAIL ovf_byte%0d got=%h exp=%h", k, got[k], {k == 0, 1'b0, 8'(8'h10 + k)}); end
      end
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", err_overflow); end
  endtask
  task automatic test_pop_at_full();
    got.delete();
    bs.byte_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_bits(8'(8'h40 + k), 8, 1'b0, 1'b0);
    send_bits(8'h50, 7, 1'b0, 1'b0);
    bs.byte_ready = 1'b1;
    bit_(1'b0, 1'b1, 1'b0);
    bs.byte_ready = 1'b0;
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL popfull_flag got=%b exp=0", err_overflow); end
    n_chk++; if (pkt_count !== 8'd4) begin n_fail++; $display("FAIL popfull_cnt got=%h exp=04", pkt_count); end
    bs.byte_ready = 1'b1;
    idle(20);
    n_chk++; if (got.size() !== 17) begin n_fail++; $display("FAIL popfull_kept got=%0d exp=17", got.size()); end
    else begin
      n_chk++; if (got[0] !== rx_entry_t'({2'b10, 8'h40})) begin n_fail++; $display("FAIL popfull_first got=%h exp=%h", got[0], {2'b10, 8'h40}); end
      n_chk++; if (got[15] !== rx_entry_t'({2'b00, 8'h4F})) begin n_fail++; $display("FAIL popfull_b15 got=%h exp=%h", got[15], {2'b00, 8'h4F}); end
      n_chk++; if (got[16] !== rx_entry_t'({2'b01, 8'h50})) begin n_fail++; $display("FAIL popfull_last got=%h exp=%h", got[16], {2'b01, 8'h50}); end
    end
  endtask
  task automatic test_reset_mid();
    got.delete();
    bs.byte_ready = 1'b0;
    send_bits(8'h55, 8, 1'b0, 1'b0);
    send_bits(8'h0F, 4, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    n_chk++; if (bs.byte_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b exp=0", bs.byte_valid); end
    n_chk++; if (pkt_count !== 8'h00) begin n_fail++; $display("FAIL rmid_cnt got=%h exp=00", pkt_count); end
    tick();
    reset_n = 1'b1;
    send_bits(8'hAA, 8, 1'b0, 1'b0);
    send_bits(8'hAA, 4, 1'b1, 1'b0);
    idle(1);
    n_chk++; if (bs.byte_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ignored got=%b exp=0", bs.byte_valid); end
    n_chk++; if ({err_partial, err_overflow} !== 2'b00) begin n_fail++; $display("FAIL rmid_flags got=%b%b exp=00", err_partial, err_overflow); end
    bs.byte_ready = 1'b1;
    send_bits(8'h3C, 8, 1'b1, 1'b0);
    idle(3);
    n_chk++; if (got.size() !== 1) begin n_fail++; $display("FAIL rmid_count got=%0d exp=1", got.size()); end
    else begin
      n_chk++; if (got[0] !== rx_entry_t'({2'b11, 8'h3C})) begin n_fail++; $display("FAIL rmid_byte got=%h exp=%h", got[0], {2'b11, 8'h3C}); end
    end
    n_chk++; if (pkt_count !== 8'd1) begin n_fail++; $display("FAIL rmid_pkt got=%h exp=01", pkt_count); end
  endtask
  task automatic test_wrap();
    bs.byte_ready = 1'b1;
    for (int k = 0; k < 254; k++) send_bits(8'(k), 8, 1'b1, 1'b0);
    n_chk++; if (pkt_count !== 8'hFF) begin n_fail++; $display("FAIL wrap_max got=%h exp=ff", pkt_count); end
    send_bits(8'h77, 8, 1'b1, 1'b0);
    n_chk++; if (pkt_count !== 8'h00) begin n_fail++; $display("FAIL wrap_zero got=%h exp=00", pkt_count); end
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got=%b exp=0", err_overflow); end
    idle(2);
  endtask
  task automatic test_empty_frame();
    frameo_n = 1'b0;
    valido_n = 1'b1;
    repeat (3) tick();
    idle(2);
    n_chk++; if (pkt_count !== 8'h00) begin n_fail++; $display("FAIL empty_cnt got=%h exp=00", pkt_count); end
    n_chk++; if (err_partial !== 1'b0) begin n_fail++; $display("FAIL empty_flag got=%b exp=0", err_partial); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_partial();
    test_clear();
    test_overflow();
    test_pop_at_full();
    test_reset_mid();
    test_wrap();
    test_empty_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
